mvm_engine: RTL and testbench

- Parametrised matrix-vector multiply engine; next-generation compute core behind the run/busy SRAM harness.
- Reads a header and operands from the input SRAM and the weight SRAM, then computes out[r] = sum_c W[r][c]*X[c] for M rows and N columns.
- Writes one DATA_WIDTH result per row to the output SRAM.
- Dimensions come from memory headers, so back-to-back jobs may use different sizes.

---
 rtl/mvm_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_mvm_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_engine.sv
// rtl/mvm_engine.sv - matrix-vector multiply engine behind the run/busy SRAM harness
//
// Computes out[r] = sum_c W[r][c] * X[c] for an M x N weight matrix read
// from the weight SRAM and an N-element vector read from the input SRAM.
// Dimensions come from word 0 of each SRAM, so back-to-back jobs may differ.
//
// Build option: MVM_SAT_EN - when defined, results saturate to the signed
// DATA_WIDTH range; otherwise the low DATA_WIDTH bits are kept.
//
// Ports:
//   clk                     rising-edge clock
//   reset_b                 asynchronous active-low reset
//   dut_run                 start request (level, ignored while busy)
//   dut_busy                job in progress
//   dut_sram_read_address   input SRAM address (X vector, header N at 0)
//   sram_dut_read_data      input SRAM data, one cycle after address
//   dut_wmem_read_address   weight SRAM address (W row-major, header M at 0)
//   wmem_dut_read_data      weight SRAM data, one cycle after address
//   dut_sram_write_enable   output SRAM write strobe
//   dut_sram_write_address  output SRAM address (OUT_BASE + row)
//   dut_sram_write_data     output SRAM data
module mvm_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int MAX_DIM    = 64,
    parameter int FRAC_BITS  = 0,
    parameter int OUT_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  dut_run,
    output logic                  dut_busy,
    output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
    output logic [ADDR_WIDTH-1:0] dut_wmem_read_address,
    input  logic [DATA_WIDTH-1:0] wmem_dut_read_data,
    output logic                  dut_sram_write_enable,
    output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
    output logic [DATA_WIDTH-1:0] dut_sram_write_data
);

    localparam int DIM_W = $clog2(MAX_DIM + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_LATCH,
        ROW_ISSUE,
        ROW_DRAIN,
        ROW_WRITE
    } state_t;

    state_t                        state;
    logic                          hdr_phase;
    logic                          acc_pend;
    logic [DIM_W-1:0]              n_dim;
    logic [DIM_W-1:0]              m_dim;
    logic [DIM_W-1:0]              r_idx;
    logic [DIM_W-1:0]              c_idx;
    logic [ADDR_WIDTH-1:0]         row_base;
    logic signed [ACC_WIDTH-1:0]   acc;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic [DIM_W-1:0]               r_next;
    logic [ADDR_WIDTH-1:0]          row_base_next;
    logic [ADDR_WIDTH-1:0]          out_addr;
    logic [ADDR_WIDTH-1:0]          out_addr_next;

    // Headers are unsigned; anything above MAX_DIM is treated as MAX_DIM.
    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DATA_WIDTH-1:0] h);
        if (h > DATA_WIDTH'(MAX_DIM))
            clamp_dim = DIM_W'(MAX_DIM);
        else
            clamp_dim = h[DIM_W-1:0];
    endfunction

    // Scale the accumulator down and fit it into one output word.
    function automatic logic [DATA_WIDTH-1:0] reduce(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> FRAC_BITS;
`ifdef MVM_SAT_EN
        if (s > $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}}))
            reduce = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (s < $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}}))
            reduce = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            reduce = s[DATA_WIDTH-1:0];
`else
        reduce = s[DATA_WIDTH-1:0];
`endif
    endfunction

    // The SRAM data present this cycle belongs to the column addressed in
    // the previous cycle; acc_pend marks that such a column is in flight.
    assign prod          = $signed(sram_dut_read_data) * $signed(wmem_dut_read_data);
    assign prod_ext      = ACC_WIDTH'(prod);
    assign acc_sum       = acc + prod_ext;
    assign r_next        = r_idx + DIM_W'(1);
    assign row_base_next = row_base + ADDR_WIDTH'(n_dim);
    assign out_addr      = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(r_idx);
    assign out_addr_next = ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(r_next);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                  <= IDLE;
            hdr_phase              <= 1'b0;
            acc_pend               <= 1'b0;
            n_dim                  <= '0;
            m_dim                  <= '0;
            r_idx                  <= '0;
            c_idx                  <= '0;
            row_base               <= '0;
            acc                    <= '0;
            dut_busy               <= 1'b0;
            dut_sram_read_address  <= '0;
            dut_wmem_read_address  <= '0;
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= '0;
            dut_sram_write_data    <= '0;
        end else begin
            dut_sram_write_enable <= 1'b0;
            if (acc_pend)
                acc <= acc_sum;

            case (state)
                IDLE: begin
                    dut_sram_read_address <= '0;
                    dut_wmem_read_address <= '0;
                    if (dut_run) begin
                        state    <= HDR_RD;
                        dut_busy <= 1'b1;
                    end
                end

                HDR_RD: begin
                    hdr_phase <= 1'b0;
                    state     <= HDR_LATCH;
                end

                // First cycle registers the clamped headers, second cycle
                // branches on them so the compare never sits on the SRAM path.
                HDR_LATCH: begin
                    if (!hdr_phase) begin
                        n_dim     <= clamp_dim(sram_dut_read_data);
                        m_dim     <= clamp_dim(wmem_dut_read_data);
                        hdr_phase <= 1'b1;
                    end else begin
                        hdr_phase <= 1'b0;
                        r_idx     <= '0;
                        c_idx     <= '0;
                        acc       <= '0;
                        row_base  <= ADDR_WIDTH'(1);
                        if (m_dim == '0) begin
                            state    <= IDLE;
                            dut_busy <= 1'b0;
                        end else if (n_dim == '0) begin
                            state                  <= ROW_WRITE;
                            dut_sram_write_enable  <= 1'b1;
                            dut_sram_write_address <= ADDR_WIDTH'(OUT_BASE);
                            dut_sram_write_data    <= '0;
                        end else begin
                            state                 <= ROW_ISSUE;
                            dut_sram_read_address <= ADDR_WIDTH'(1);
                            dut_wmem_read_address <= ADDR_WIDTH'(1);
                        end
                    end
                end

                ROW_ISSUE: begin
                    acc_pend <= 1'b1;
                    if (c_idx == n_dim - DIM_W'(1)) begin
                        state <= ROW_DRAIN;
                    end else begin
                        c_idx                 <= c_idx + DIM_W'(1);
                        dut_sram_read_address <= dut_sram_read_address + ADDR_WIDTH'(1);
                        dut_wmem_read_address <= dut_wmem_read_address + ADDR_WIDTH'(1);
                    end
                end

                // Last product lands here; the written value includes it.
                ROW_DRAIN: begin
                    acc_pend               <= 1'b0;
                    state                  <= ROW_WRITE;
                    dut_sram_write_enable  <= 1'b1;
                    dut_sram_write_address <= out_addr;
                    dut_sram_write_data    <= reduce(acc_sum);
                end

                ROW_WRITE: begin
                    acc <= '0;
                    if (r_idx == m_dim - DIM_W'(1)) begin
                        state                 <= IDLE;
                        dut_busy              <= 1'b0;
                        dut_sram_read_address <= '0;
                        dut_wmem_read_address <= '0;
                    end else begin
                        r_idx    <= r_next;
                        c_idx    <= '0;
                        row_base <= row_base_next;
                        if (n_dim == '0) begin
                            state                  <= ROW_WRITE;
                            dut_sram_write_enable  <= 1'b1;
                            dut_sram_write_address <= out_addr_next;
                            dut_sram_write_data    <= '0;
                        end else begin
                            state                 <= ROW_ISSUE;
                            dut_sram_read_address <= ADDR_WIDTH'(1);
                            dut_wmem_read_address <= row_base_next;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    dut_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_engine.sv
// tb/tb_mvm_engine.sv - scoreboard bench for mvm_engine
module tb_mvm_engine;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          dut_run;
    logic          dut_busy;
    logic [AW-1:0] dut_sram_read_address;
    logic [DW-1:0] sram_dut_read_data;
    logic [AW-1:0] dut_wmem_read_address;
    logic [DW-1:0] wmem_dut_read_data;
    logic          dut_sram_write_enable;
    logic [AW-1:0] dut_sram_write_address;
    logic [DW-1:0] dut_sram_write_data;

    logic [DW-1:0] imem [0:4095];
    logic [DW-1:0] wmem [0:4095];

    int            checks   = 0;
    int            failures = 0;
    logic [27:0]   exp_wr[$];
    int            exp_busy[$];
    int            busy_cnt = 0;
    logic [27:0]   wr_e;
    int            busy_e;

    always #5 clk = ~clk;

    mvm_engine dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data)
    );

    always @(posedge clk) begin
        sram_dut_read_data <= imem[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Write and busy-length monitor: pops expectations as the DUT produces them.
    always @(negedge clk) begin
        if (dut_sram_write_enable) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h:%h required=none",
                         dut_sram_write_address, dut_sram_write_data);
            end else begin
                wr_e = exp_wr.pop_front();
                check("write_addr_data", {4'h0, dut_sram_write_address, dut_sram_write_data},
                      {4'h0, wr_e});
            end
            check("write_inside_busy", {31'd0, dut_busy}, 32'd1);
        end
        if (dut_busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            if (exp_busy.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_busy actual=%0d required=none", busy_cnt);
            end else begin
                busy_e = exp_busy.pop_front();
                if (busy_e >= 0)
                    check("busy_len", busy_cnt, busy_e);
            end
            busy_cnt = 0;
        end
    end

    task automatic wait_busy(input logic lvl);
        for (int k = 0; k < 2000 && dut_busy !== lvl; k++)
            @(negedge clk);
        if (dut_busy !== lvl) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout actual=%b required=%b", dut_busy, lvl);
        end
    endtask

    task automatic do_job();
        @(negedge clk);
        dut_run = 1'b1;
        wait_busy(1'b1);
        @(negedge clk);
        dut_run = 1'b0;
        wait_busy(1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = '0;
            wmem[i] = '0;
        end
    endtask

    task automatic load_t1();
        clear_mems();
        imem[0] = 16'd2; imem[1] = 16'd5; imem[2] = 16'd6;
        wmem[0] = 16'd1; wmem[1] = 16'd3; wmem[2] = 16'd4;
    endtask

    initial begin
        reset_b = 1'b0;
        dut_run = 1'b0;
        clear_mems();
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, dut_busy}, 32'd0);
        check("rst_we", {31'd0, dut_sram_write_enable}, 32'd0);
        check("rst_raddr", {8'd0, dut_sram_read_address, dut_wmem_read_address}, 32'd0);
        check("rst_wr", {4'd0, dut_sram_write_address, dut_sram_write_data}, 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, dut_busy}, 32'd0);

        // N=2 M=1: 3*5 + 4*6 = 39
        load_t1();
        exp_wr.push_back({12'h000, 16'h0027});
        exp_busy.push_back(7);
        do_job();

        // N=1 M=1: 0x7FFF^2 = 0x3FFF0001
        clear_mems();
        imem[0] = 16'd1; imem[1] = 16'h7FFF;
        wmem[0] = 16'd1; wmem[1] = 16'h7FFF;
`ifdef MVM_SAT_EN
        exp_wr.push_back({12'h000, 16'h7FFF});
`else
        exp_wr.push_back({12'h000, 16'h0001});
`endif
        exp_busy.push_back(6);
        do_job();

        // N=3 M=2 with negative operands
        clear_mems();
        imem[0] = 16'd3; imem[1] = 16'd3; imem[2] = 16'd7; imem[3] = 16'hFFFF;
        wmem[0] = 16'd2;
        wmem[1] = 16'hFFFE; wmem[2] = 16'd0; wmem[3] = 16'd1;
        wmem[4] = 16'd1;    wmem[5] = 16'd1; wmem[6] = 16'd1;
        exp_wr.push_back({12'h000, 16'hFFF9});
        exp_wr.push_back({12'h001, 16'h0009});
        exp_busy.push_back(13);
        do_job();

        // N=0 M=3: three zero writes
        clear_mems();
        imem[0] = 16'd0;
        wmem[0] = 16'd3;
        exp_wr.push_back({12'h000, 16'h0000});
        exp_wr.push_back({12'h001, 16'h0000});
        exp_wr.push_back({12'h002, 16'h0000});
        exp_busy.push_back(6);
        do_job();

        // N=100 clamps to 64: sum of 64 ones
        clear_mems();
        imem[0] = 16'd100;
        wmem[0] = 16'd1;
        for (int i = 1; i <= 100; i++) begin
            imem[i] = 16'd1;
            wmem[i] = 16'd1;
        end
        exp_wr.push_back({12'h000, 16'h0040});
        exp_busy.push_back(69);
        do_job();

        // Reset during row 1 of an M=4 job: only row 0 is written
        clear_mems();
        imem[0] = 16'd2; imem[1] = 16'd1; imem[2] = 16'd1;
        wmem[0] = 16'd4;
        for (int i = 1; i <= 8; i++)
            wmem[i] = 16'd1;
        exp_wr.push_back({12'h000, 16'h0002});
        exp_busy.push_back(-1);
        @(negedge clk);
        dut_run = 1'b1;
        wait_busy(1'b1);
        @(negedge clk);
        dut_run = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (exp_wr.size() == 0)
                break;
        end
        check("row0_before_reset", exp_wr.size(), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("midjob_rst_busy", {31'd0, dut_busy}, 32'd0);
        check("midjob_rst_we", {31'd0, dut_sram_write_enable}, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);

        load_t1();
        exp_wr.push_back({12'h000, 16'h0027});
        exp_busy.push_back(7);
        do_job();

        // Back-to-back with run held: job 1 N=2 M=1, job 2 N=4 M=2
        clear_mems();
        imem[0] = 16'd2;
        imem[1] = 16'd1; imem[2] = 16'd2; imem[3] = 16'd3; imem[4] = 16'd4;
        wmem[0] = 16'd1;
        wmem[1] = 16'd1; wmem[2] = 16'd1; wmem[3] = 16'd1; wmem[4] = 16'd1;
        wmem[5] = 16'd2; wmem[6] = 16'hFFFF; wmem[7] = 16'd0; wmem[8] = 16'd5;
        exp_wr.push_back({12'h000, 16'h0003});
        exp_wr.push_back({12'h000, 16'h000A});
        exp_wr.push_back({12'h001, 16'h0014});
        exp_busy.push_back(7);
        exp_busy.push_back(15);
        @(negedge clk);
        dut_run = 1'b1;
        wait_busy(1'b1);
        repeat (3) @(negedge clk);
        imem[0] = 16'd4;
        wmem[0] = 16'd2;
        wait_busy(1'b0);
        wait_busy(1'b1);
        @(negedge clk);
        dut_run = 1'b0;
        wait_busy(1'b0);
        repeat (3) @(negedge clk);

        check("writes_drained", exp_wr.size(), 32'd0);
        check("jobs_drained", exp_busy.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
